// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared types and constants for the conditional issue controller
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fsm_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[N_IDX];
    assign z = nzcv[Z_IDX];
    assign c = nzcv[C_IDX];
    assign v = nzcv[V_IDX];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ: pass = z;
            NE: pass = ~z;
            CS: pass = c;
            CC: pass = ~c;
            MI: pass = n;
            PL: pass = ~n;
            VS: pass = v;
            VC: pass = ~v;
            HI: pass = c & ~z;
            LS: pass = ~c | z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = ~z & (n == v);
            LE: pass = z | (n != v);
            AL: pass = 1'b1;
            NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_issue_ctrl.sv
// rtl/cond_issue_ctrl.sv - issue-stage scheduler holding conditional instructions until NZCV resolves
module cond_issue_ctrl
    import cond_pkg::*;
#(
    parameter int FLAG_LAT = 2,
    parameter int STALL_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [3:0]         id_cond,
    input  logic               id_s,
    input  logic               ex_flag_we,
    input  logic [3:0]         ex_flags,
    input  logic               flush,
    output logic               issue,
    output logic               exec_en,
    output logic [3:0]         status,
    output logic               state_hold,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [FLAG_LAT-1:0] pend;
    logic [FLAG_LAT-1:0] pend_shift;
    logic [3:0]          ef;
    logic                pass;
    logic                busy;
    logic                reads_flags;
    logic                hazard;
    logic                wr_set;
    fsm_e                state;
    fsm_e                state_nxt;

    assign ef = ex_flag_we ? ex_flags : status;

    cond_eval u_cond_eval (
        .cond (id_cond),
        .nzcv (ef),
        .pass (pass)
    );

    // AL and NV never look at the flags, so they may issue past pending writers
    assign reads_flags = (id_cond != 4'(AL)) && (id_cond != 4'(NV));
    assign wr_set      = issue & exec_en & id_s;

    generate
        if (FLAG_LAT > 1) begin : g_multi
            logic pend_now_unused;
            // pend[0] marks a write landing this cycle; the bypass already covers it
            assign pend_now_unused = pend[0];
            assign busy            = |pend[FLAG_LAT-1:1];
            assign pend_shift      = {wr_set, pend[FLAG_LAT-1:1]};
        end else begin : g_single
            logic pend_now_unused;
            assign pend_now_unused = pend[0];
            assign busy            = 1'b0;
            assign pend_shift      = wr_set;
        end
    endgenerate

    assign hazard     = reads_flags & busy;
    assign id_ready   = ~hazard & ~flush;
    assign issue      = id_valid & id_ready;
    assign exec_en    = issue & pass;
    assign state_hold = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= 4'b0000;
        end else if (ex_flag_we) begin
            status <= ex_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            pend <= pend_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (id_valid && hazard && !flush) state_nxt = HOLD;
            HOLD:    if (!hazard || flush)             state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// tb/tb_cond_issue_ctrl.sv - directed and randomized self-checking bench for cond_issue_ctrl
module tb_cond_issue_ctrl;

    localparam int L = 2;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic          id_ready;
    logic [3:0]    id_cond = 4'd0;
    logic          id_s = 1'b0;
    logic          ex_flag_we = 1'b0;
    logic [3:0]    ex_flags = 4'd0;
    logic          flush = 1'b0;
    logic          issue;
    logic          exec_en;
    logic [3:0]    status;
    logic          state_hold;
    logic [SW-1:0] stall_cnt;

    cond_issue_ctrl #(.FLAG_LAT(L), .STALL_W(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_cond    (id_cond),
        .id_s       (id_s),
        .ex_flag_we (ex_flag_we),
        .ex_flags   (ex_flags),
        .flush      (flush),
        .issue      (issue),
        .exec_en    (exec_en),
        .status     (status),
        .state_hold (state_hold),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [3:0] st_m = 4'd0;
    bit         hold_m = 1'b0;
    int         cnt_m = 0;
    int         due_q[$];

    logic          o_ready, o_issue, o_exec, o_hold;
    logic [SW-1:0] o_cnt;
    logic [3:0]    o_status;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ARM-style: condition pairs share a test, odd codes invert it
    function automatic bit pass_m(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, r;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cc;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cc & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'd15) return 1'b0;
        if (c == 4'd14) return 1'b1;
        return r ^ c[0];
    endfunction

    function automatic bit busy_m();
        foreach (due_q[i]) if (due_q[i] > cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit due_now();
        foreach (due_q[i]) if (due_q[i] == cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input bit v, input logic [3:0] c, input bit s,
                        input bit we, input logic [3:0] f, input bit fl);
        bit hz, rdy, iss, ex;
        logic [3:0] ef;
        int keep[$];
        @(negedge clk);
        id_valid = v; id_cond = c; id_s = s;
        ex_flag_we = we; ex_flags = f; flush = fl;
        #1;
        hz  = (c != 4'd14) && (c != 4'd15) && busy_m();
        rdy = !hz && !fl;
        iss = v && rdy;
        ef  = we ? f : st_m;
        ex  = iss && pass_m(c, ef);
        o_ready = id_ready; o_issue = issue; o_exec = exec_en;
        o_hold = state_hold; o_cnt = stall_cnt; o_status = status;
        chk("id_ready", {31'd0, o_ready}, {31'd0, rdy});
        chk("issue", {31'd0, o_issue}, {31'd0, iss});
        chk("exec_en", {31'd0, o_exec}, {31'd0, ex});
        chk("status", {28'd0, o_status}, {28'd0, st_m});
        chk("state_hold", {31'd0, o_hold}, {31'd0, hold_m});
        chk("stall_cnt", {16'd0, o_cnt}, cnt_m);
        @(posedge clk);
        if (we) st_m = f;
        if (v && !rdy && cnt_m != 32'hffff) cnt_m++;
        hold_m = hz && !fl && (hold_m || v);
        if (fl) due_q.delete();
        else begin
            foreach (due_q[i]) if (due_q[i] > cyc) keep.push_back(due_q[i]);
            due_q = keep;
            if (iss && ex && s) due_q.push_back(cyc + L);
        end
        cyc++;
    endtask

    task automatic clear_model();
        st_m = 4'd0; hold_m = 1'b0; cnt_m = 0; due_q.delete();
    endtask

    task automatic do_reset(input bit keep_inputs);
        @(negedge clk);
        if (!keep_inputs) begin
            id_valid = 1'b0; ex_flag_we = 1'b0; flush = 1'b0; id_s = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_status", {28'd0, status}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_hold", {31'd0, state_hold}, 32'd0);
        chk("rst_ready", {31'd0, id_ready}, {31'd0, !flush});
        chk("rst_issue", {31'd0, issue}, {31'd0, id_valid && !flush});
        clear_model();
        @(negedge clk);
        id_valid = 1'b0; ex_flag_we = 1'b0; flush = 1'b0; id_s = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        bit rv, rs, held, rwe, rfl;
        logic [3:0] rc, rf;
        held = 1'b0; rv = 1'b0; rc = 4'd0; rs = 1'b0;

        do_reset(1'b0);

        // flag write then EQ / NE against committed status
        step(0, 4'd0, 0, 1, 4'b0100, 0);
        step(1, 4'd0, 0, 0, 4'b0000, 0);
        chk("t1_status", {28'd0, o_status}, 32'h4);
        chk("t1_eq_exec", {31'd0, o_exec}, 32'd1);
        step(1, 4'd1, 0, 0, 4'b0000, 0);
        chk("t1_ne_exec", {31'd0, o_exec}, 32'd0);

        // SUBS then EQ: one stall, released by bypassed write
        step(1, 4'd14, 1, 0, 4'b0000, 0);
        step(1, 4'd0, 0, 0, 4'b0000, 0);
        chk("t2_ready", {31'd0, o_ready}, 32'd0);
        step(1, 4'd0, 0, 1, 4'b0100, 0);
        chk("t2_hold", {31'd0, o_hold}, 32'd1);
        chk("t2_issue", {31'd0, o_issue}, 32'd1);
        chk("t2_exec", {31'd0, o_exec}, 32'd1);
        chk("t2_cnt", {16'd0, o_cnt}, 32'd1);

        // AL never stalls behind a pending writer
        step(1, 4'd14, 1, 0, 4'b0000, 0);
        step(1, 4'd14, 0, 0, 4'b0000, 0);
        chk("t3_ready_a", {31'd0, o_ready}, 32'd1);
        step(1, 4'd14, 0, 1, 4'b0100, 0);
        chk("t3_ready_b", {31'd0, o_ready}, 32'd1);
        step(0, 4'd0, 0, 0, 4'b0000, 0);
        chk("t3_cnt", {16'd0, o_cnt}, 32'd1);

        // signed compares and NV
        step(1, 4'd13, 0, 1, 4'b1000, 0);
        chk("t4_le_n", {31'd0, o_exec}, 32'd1);
        step(1, 4'd13, 0, 1, 4'b0000, 0);
        chk("t4_le_0", {31'd0, o_exec}, 32'd0);
        step(1, 4'd12, 0, 0, 4'b0000, 0);
        chk("t4_gt_0", {31'd0, o_exec}, 32'd1);
        step(1, 4'd15, 0, 0, 4'b0000, 0);
        chk("t4_nv_issue", {31'd0, o_issue}, 32'd1);
        chk("t4_nv_exec", {31'd0, o_exec}, 32'd0);

        // condition-failed S instruction leaves no pending write
        step(1, 4'd0, 1, 0, 4'b0000, 0);
        chk("t5_fail", {31'd0, o_exec}, 32'd0);
        step(1, 4'd1, 0, 0, 4'b0000, 0);
        chk("t5_no_stall", {31'd0, o_ready}, 32'd1);

        // flush while held, then reset mid-stall
        step(1, 4'd14, 1, 0, 4'b0000, 0);
        step(1, 4'd0, 0, 0, 4'b0000, 0);
        step(1, 4'd0, 0, 0, 4'b0000, 1);
        chk("t6_flush_ready", {31'd0, o_ready}, 32'd0);
        chk("t6_flush_hold", {31'd0, o_hold}, 32'd1);
        step(1, 4'd0, 0, 0, 4'b0000, 0);
        chk("t6_after_hold", {31'd0, o_hold}, 32'd0);
        chk("t6_after_ready", {31'd0, o_ready}, 32'd1);
        step(1, 4'd14, 1, 1, 4'b1011, 0);
        step(1, 4'd0, 0, 0, 4'b0000, 0);
        chk("t6_pre_status", {28'd0, o_status}, 32'hb);
        do_reset(1'b1);

        // randomized traffic against the model
        repeat (600) begin
            if (!held) begin
                rv = ($urandom % 4) != 0;
                rc = ($urandom % 3 == 0) ? 4'd14 : 4'($urandom);
                rs = $urandom % 2;
            end
            rwe = due_now() || ($urandom % 5 == 0);
            rf  = 4'($urandom);
            rfl = ($urandom % 12) == 0;
            step(rv, rc, rs, rwe, rf, rfl);
            held = rv && !o_issue;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
